// File: rtl/addr_seq_ctrl.sv
// addr_seq_ctrl: reads a run of RAM words starting at base_addr and streams them out, marking the final word.
// Define ADDR_SEQ_BACKPRESSURE_EN to honour out_ready through a 2-entry buffer; otherwise out_ready is ignored.

module addr_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        abort,
    input  logic [9:0]  base_addr,
    input  logic [10:0] length,
    output logic        mem_en,
    output logic [9:0]  mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e      state_q;
    logic [9:0]  addr_q;
    logic [10:0] remaining_q;
    logic        inflight_q;
    logic        inflightLast_q;
    logic [10:0] lengthSat;
    logic        flush;
    logic        issueLast;
    logic        drained;

    assign lengthSat = (length > 11'd1024) ? 11'd1024 : length;
    assign flush     = abort && ((state_q == RUN) || (state_q == DRAIN));
    assign issueLast = mem_en && (remaining_q == 11'd1);
    assign mem_addr  = addr_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

`ifdef ADDR_SEQ_BACKPRESSURE_EN
    logic [1:0]  occ_q;
    logic [1:0]  occ_d;
    logic [15:0] data0_q;
    logic [15:0] data1_q;
    logic        last0_q;
    logic        last1_q;
    logic        pop;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = data0_q;
    assign out_last  = out_valid && last0_q;
    assign pop       = out_valid && out_ready;
    // Occupancy once this cycle ends; a read is only issued if its word will still find a free slot
    assign occ_d     = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign mem_en    = (state_q == RUN) && (remaining_q != 11'd0) && (occ_d < 2'd2);
    assign drained   = !inflight_q && (occ_d == 2'd0);

    // Entry 0 is always the head, so out_data only moves when the head word is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= 2'd0;
            data0_q <= 16'd0;
            data1_q <= 16'd0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else if (flush) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
            case ({inflight_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        data0_q <= mem_rdata;
                        last0_q <= inflightLast_q;
                    end else begin
                        data1_q <= mem_rdata;
                        last1_q <= inflightLast_q;
                    end
                end
                2'b01: begin
                    data0_q <= data1_q;
                    last0_q <= last1_q;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        data0_q <= mem_rdata;
                        last0_q <= inflightLast_q;
                    end else begin
                        data0_q <= data1_q;
                        last0_q <= last1_q;
                        data1_q <= mem_rdata;
                        last1_q <= inflightLast_q;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic        valid_q;
    logic        last_q;
    logic [15:0] data_q;
    logic        unusedReady;

    // Without backpressure the consumer is assumed always ready
    assign unusedReady = out_ready;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_last    = last_q;
    assign mem_en      = (state_q == RUN);
    assign drained     = !inflight_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= 16'd0;
        end else if (flush) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= inflight_q;
            last_q  <= inflightLast_q;
            if (inflight_q) begin
                data_q <= mem_rdata;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= 10'd0;
            remaining_q    <= 11'd0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
        end else begin
            inflight_q     <= mem_en && !flush;
            inflightLast_q <= issueLast && !flush;
            case (state_q)
                IDLE: begin
                    if (go) begin
                        addr_q      <= base_addr;
                        remaining_q <= lengthSat;
                        state_q     <= (lengthSat == 11'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q     <= IDLE;
                        remaining_q <= 11'd0;
                    end else if (mem_en) begin
                        addr_q      <= addr_q + 10'd1;
                        remaining_q <= remaining_q - 11'd1;
                        if (remaining_q == 11'd1) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (drained) begin
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/addr_seq_ctrl.md
ADDR_SEQ_CTRL -- requirements
Module: addr_seq_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port go, input, 1 bit: start request, sampled in IDLE only.
REQ-004 The block SHALL have the port abort, input, 1 bit: cancel the transfer in progress.
REQ-005 The block SHALL have the port base_addr, input, 10 bits: first word address, latched on accepted go.
REQ-006 The block SHALL have the port length, input, 11 bits: word count, latched on accepted go; values above 1024 saturate to 1024.
REQ-007 The block SHALL have the port mem_en, output, 1 bit: read strobe to the RAM.
REQ-008 The block SHALL have the port mem_addr, output, 10 bits: read address to the RAM.
REQ-009 The block SHALL have the port mem_rdata, input, 16 bits: RAM data, valid the cycle after mem_en.
REQ-010 The block SHALL have the port out_valid, output, 1 bit: stream data valid.
REQ-011 The block SHALL have the port out_data, output, 16 bits: stream data.
REQ-012 The block SHALL have the port out_last, output, 1 bit: marks the final word of the transfer.
REQ-013 The block SHALL have the port out_ready, input, 1 bit: consumer ready; a beat transfers when out_valid and out_ready are both high.
REQ-014 The block SHALL have the port busy, output, 1 bit: high in RUN and DRAIN.
REQ-015 The block SHALL have the port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE; DONE SHALL last exactly one cycle and then go to IDLE.
REQ-017 In IDLE, go=1 SHALL latch base_addr and length, and enter RUN, or DONE if length=0; go SHALL be ignored in every other state.
REQ-018 In RUN, mem_en SHALL be 1 in a cycle iff remaining>0 and (inflight + occupancy - pop) < 2, where inflight is the mem_en of the previous cycle, occupancy is the 2-entry buffer count, and pop is out_valid&out_ready.
REQ-019 Every mem_en cycle SHALL advance mem_addr by 1 modulo 1024 (1023 wraps to 0) and decrement remaining by 1.
REQ-020 mem_rdata SHALL be captured into the buffer at the end of the cycle after its mem_en, so out_valid rises 2 cycles after the corresponding mem_en.
REQ-021 With out_ready held at 1, the block SHALL sustain one word per cycle with no bubbles.
REQ-022 out_valid and out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 The buffer SHALL never overflow, and words SHALL be delivered in address order.
REQ-024 out_last SHALL be 1 only with the final word of the transfer.
REQ-025 RUN SHALL go to DRAIN when remaining reaches 0.
REQ-026 DRAIN SHALL go to DONE when inflight=0 and the buffer is empty.
REQ-027 done SHALL be 1 only in DONE, and busy SHALL be 1 only in RUN or DRAIN.
REQ-028 abort=1 in RUN or DRAIN SHALL go to IDLE on the next edge, flush the buffer, drop in-flight data and not pulse done; abort SHALL take priority over every other transition in the same cycle.
REQ-029 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL immediately force the FSM to IDLE, clear the buffer, remaining and inflight, and drive mem_addr=0 and mem_en, out_valid, out_last, busy and done to 0, including mid-transfer.
REQ-031 out_data SHALL reset to 0.

Configuration
REQ-032 With ADDR_SEQ_BACKPRESSURE_EN defined, REQ-018 to REQ-023 SHALL apply as written.
REQ-033 With ADDR_SEQ_BACKPRESSURE_EN undefined, out_ready SHALL be ignored (treated as 1), the buffer SHALL be omitted, mem_en SHALL be 1 on every RUN cycle, and out_valid/out_data SHALL be mem_en/mem_rdata delayed by 2 cycles with 2-cycle latency kept.

Verification
REQ-034 The bench SHALL apply base=5, length=4, out_ready=1 and require mem_addr 5,6,7,8 on 4 consecutive cycles, 4 back-to-back beats with out_last on the 4th, and done exactly 1 cycle after the last beat.
REQ-035 The bench SHALL apply base=1022, length=4 and require addresses 1022,1023,0,1 with in-order data.
REQ-036 The bench SHALL apply length=8 with out_ready toggled randomly and require 8 beats with no loss or duplication, mem_en stalled while the buffer is full, and data stable under stall.
REQ-037 The bench SHALL apply length=0 and require done one cycle after go, with no mem_en and no out_valid.
REQ-038 The bench SHALL apply abort on the 3rd RUN cycle of a length=10 transfer together with go, and require IDLE next cycle, no done, no further beats, and go ignored.
REQ-039 The bench SHALL drop rst_n mid-DRAIN and require all outputs at reset values immediately, after which a new transfer completes normally.
